// File: rtl/cva6_tlb_miss_pkg.sv
// Shared types and constants for the ITLB/DTLB miss arbiter.
package cva6_tlb_miss_pkg;

  // Arbiter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Miss sources. The encoding doubles as the slot index (0 = ITLB, 1 = DTLB).
  typedef enum logic {
    REQ_ITLB = 1'b0,
    REQ_DTLB = 1'b1
  } requester_e;

  localparam int unsigned PERF_CNT_W = 32;

  // Wrapping event counter step.
  function automatic logic [PERF_CNT_W-1:0] perf_inc(input logic [PERF_CNT_W-1:0] cnt,
                                                     input logic                  en);
    return en ? cnt + 1'b1 : cnt;
  endfunction

endpackage

// File: rtl/cva6_tlb_miss_slot.sv
// Single-entry miss capture register: holds one outstanding miss vaddr per TLB.
// A miss is taken only when the slot is empty and no flush is active; later
// misses while occupied are dropped.
module cva6_tlb_miss_slot
  import cva6_tlb_miss_pkg::*;
#(
  parameter int unsigned VLEN = 39
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            miss_i,
  input  logic [VLEN-1:0] vaddr_i,
  input  logic            flush_i,
  input  logic            clear_i,
  output logic            valid_o,
  output logic [VLEN-1:0] vaddr_o,
  output logic            capture_o
);

  logic            valid_q, valid_d;
  logic [VLEN-1:0] vaddr_q, vaddr_d;
  logic            capture;

  assign capture = miss_i & ~valid_q & ~flush_i;

  // Next slot contents: flush beats clear beats capture.
  always_comb begin
    valid_d = valid_q;
    vaddr_d = vaddr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      vaddr_d = vaddr_i;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      vaddr_q <= '0;
    end else begin
      valid_q <= valid_d;
      vaddr_q <= vaddr_d;
    end
  end

  assign valid_o   = valid_q;
  assign vaddr_o   = vaddr_q;
  assign capture_o = capture;

endmodule

// File: rtl/cva6_tlb_miss_arbiter.sv
// ITLB/DTLB miss arbiter in front of the shared-TLB/PTW request path.
// One outstanding miss per source, round-robin grant, a single walk in
// flight, one-cycle update pulse back to the originating TLB, and flush
// handling that drains an already-accepted walk without reporting it.
// Optional build macro TLB_MISS_PERF_CNT_EN adds three 32-bit perf counters;
// without it the perf outputs are tied to zero.
module cva6_tlb_miss_arbiter
  import cva6_tlb_miss_pkg::*;
#(
  parameter int unsigned VLEN        = 39,
  parameter int unsigned UPD_W       = 64,
  parameter int unsigned PAGE_OFFSET = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  itlb_miss_i,
  input  logic [VLEN-1:0]       itlb_vaddr_i,
  input  logic                  dtlb_miss_i,
  input  logic [VLEN-1:0]       dtlb_vaddr_i,
  output logic                  itlb_busy_o,
  output logic                  dtlb_busy_o,
  output logic                  ptw_req_valid_o,
  input  logic                  ptw_req_ready_i,
  output logic [VLEN-1:0]       ptw_req_vaddr_o,
  output logic                  ptw_req_is_itlb_o,
  input  logic                  ptw_rsp_valid_i,
  input  logic [UPD_W-1:0]      ptw_rsp_i,
  input  logic                  ptw_rsp_error_i,
  output logic                  itlb_update_valid_o,
  output logic                  dtlb_update_valid_o,
  output logic [UPD_W-1:0]      update_o,
  output logic                  update_error_o,
  output logic [PERF_CNT_W-1:0] perf_itlb_miss_o,
  output logic [PERF_CNT_W-1:0] perf_dtlb_miss_o,
  output logic [PERF_CNT_W-1:0] perf_wait_cycles_o
);

  localparam logic [VLEN-1:0] PAGE_MASK = {{(VLEN-PAGE_OFFSET){1'b1}}, {PAGE_OFFSET{1'b0}}};

  // Per-source slot wiring, indexed by requester_e.
  logic [1:0]      slot_miss;
  logic [1:0]      slot_clear;
  logic [1:0]      slot_valid;
  logic [1:0]      slot_capture;
  logic [VLEN-1:0] slot_vaddr_in [2];
  logic [VLEN-1:0] slot_vaddr    [2];

  assign slot_miss[REQ_ITLB]     = itlb_miss_i;
  assign slot_miss[REQ_DTLB]     = dtlb_miss_i;
  assign slot_vaddr_in[REQ_ITLB] = itlb_vaddr_i;
  assign slot_vaddr_in[REQ_DTLB] = dtlb_vaddr_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    cva6_tlb_miss_slot #(
      .VLEN (VLEN)
    ) i_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .miss_i    (slot_miss[gi]),
      .vaddr_i   (slot_vaddr_in[gi]),
      .flush_i   (flush_i),
      .clear_i   (slot_clear[gi]),
      .valid_o   (slot_valid[gi]),
      .vaddr_o   (slot_vaddr[gi]),
      .capture_o (slot_capture[gi])
    );
  end

  // Control state and latched request / response.
  state_e           state_q, state_d;
  requester_e       last_q, last_d;       // source granted most recently
  requester_e       req_src_q, req_src_d; // origin of the walk in flight
  logic [VLEN-1:0]  req_vaddr_q, req_vaddr_d;
  logic [1:0]       upd_valid_q, upd_valid_d;
  logic [UPD_W-1:0] update_q, update_d;
  logic             update_error_q, update_error_d;
  requester_e       gnt;

  // Next-state, grant, slot release and response capture.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    req_src_d      = req_src_q;
    req_vaddr_d    = req_vaddr_q;
    upd_valid_d    = 2'b00;
    update_d       = update_q;
    update_error_d = update_error_q;
    slot_clear     = 2'b00;
    gnt            = REQ_DTLB;

    case (state_q)
      IDLE: begin
        // A flush in the same cycle empties the slots, so nothing is granted.
        if (!flush_i && (slot_valid != 2'b00)) begin
          if (slot_valid == 2'b11) begin
            gnt = (last_q == REQ_ITLB) ? REQ_DTLB : REQ_ITLB;
          end else begin
            gnt = slot_valid[REQ_ITLB] ? REQ_ITLB : REQ_DTLB;
          end
          last_d      = gnt;
          req_src_d   = gnt;
          req_vaddr_d = slot_vaddr[gnt] & PAGE_MASK;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (flush_i) begin
          // Accepted walks must still be drained; unaccepted ones are withdrawn.
          state_d = ptw_req_ready_i ? DRAIN : IDLE;
        end else if (ptw_req_ready_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (flush_i) begin
          // A response arriving with the flush is the one in flight: drop it.
          state_d = ptw_rsp_valid_i ? IDLE : DRAIN;
        end else if (ptw_rsp_valid_i) begin
          upd_valid_d[req_src_q] = 1'b1;
          update_d               = ptw_rsp_i;
          update_error_d         = ptw_rsp_error_i;
          slot_clear[req_src_q]  = 1'b1;
          state_d                = IDLE;
        end
      end

      DRAIN: begin
        if (ptw_rsp_valid_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset favours DTLB on the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      last_q         <= REQ_ITLB;
      req_src_q      <= REQ_DTLB;
      req_vaddr_q    <= '0;
      upd_valid_q    <= 2'b00;
      update_q       <= '0;
      update_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      req_src_q      <= req_src_d;
      req_vaddr_q    <= req_vaddr_d;
      upd_valid_q    <= upd_valid_d;
      update_q       <= update_d;
      update_error_q <= update_error_d;
    end
  end

  assign itlb_busy_o         = slot_valid[REQ_ITLB];
  assign dtlb_busy_o         = slot_valid[REQ_DTLB];
  assign ptw_req_valid_o     = (state_q == REQ);
  assign ptw_req_vaddr_o     = req_vaddr_q;
  assign ptw_req_is_itlb_o   = (req_src_q == REQ_ITLB);
  assign itlb_update_valid_o = upd_valid_q[REQ_ITLB];
  assign dtlb_update_valid_o = upd_valid_q[REQ_DTLB];
  assign update_o            = update_q;
  assign update_error_o      = update_error_q;

`ifdef TLB_MISS_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_itlb_q, perf_itlb_d;
  logic [PERF_CNT_W-1:0] perf_dtlb_q, perf_dtlb_d;
  logic [PERF_CNT_W-1:0] perf_wait_q, perf_wait_d;

  // Count captures per source and cycles spent with a walk requested or pending.
  always_comb begin
    perf_itlb_d = perf_inc(perf_itlb_q, slot_capture[REQ_ITLB]);
    perf_dtlb_d = perf_inc(perf_dtlb_q, slot_capture[REQ_DTLB]);
    perf_wait_d = perf_inc(perf_wait_q, (state_q == REQ) || (state_q == WAIT));
  end

  // Counter registers; only reset clears them, flush does not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_itlb_q <= '0;
      perf_dtlb_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_itlb_q <= perf_itlb_d;
      perf_dtlb_q <= perf_dtlb_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_itlb_miss_o   = perf_itlb_q;
  assign perf_dtlb_miss_o   = perf_dtlb_q;
  assign perf_wait_cycles_o = perf_wait_q;
`else
  logic unused_capture;
  assign unused_capture     = ^slot_capture;
  assign perf_itlb_miss_o   = '0;
  assign perf_dtlb_miss_o   = '0;
  assign perf_wait_cycles_o = '0;
`endif

endmodule
